// File: rtl/de2_115_qsys_led_blink_pio.sv
// Avalon-MM LED output port with atomic set/clear, per-bit blink enable and a
// programmable blink timebase; out_port drives the LED pins directly.
module de2_115_qsys_led_blink_pio #(
  parameter int unsigned           DATA_WIDTH  = 9,
  parameter int unsigned           CNT_WIDTH   = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_BLINK  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  logic                  data_r;
  logic [DATA_WIDTH-1:0] data_q_r;
  logic [DATA_WIDTH-1:0] blink_r;
  logic [CNT_WIDTH-1:0]  period_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  phase_r;
  logic [DATA_WIDTH-1:0] out_r;

  logic [DATA_WIDTH-1:0] data_s;
  logic [DATA_WIDTH-1:0] blink_s;
  logic [CNT_WIDTH-1:0]  period_s;
  logic [CNT_WIDTH-1:0]  cnt_s;
  logic                  phase_s;
  logic                  wr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [CNT_WIDTH-1:0]  wperiod_s;
  logic                  unused_wdata_s;

  assign wr_s           = chipselect & ~write_n;
  assign wdata_s        = writedata[DATA_WIDTH-1:0];
  assign wperiod_s      = writedata[CNT_WIDTH-1:0];
  assign unused_wdata_s = ^writedata;
  assign data_r         = 1'b0;

  // Next-state: free-running timebase first, then a bus write may override it.
  always_comb begin
    data_s   = data_q_r;
    blink_s  = blink_r;
    period_s = period_r;
    cnt_s    = cnt_r;
    phase_s  = phase_r;

    if (period_r == CNT_ZERO) begin
      cnt_s   = CNT_ZERO;
      phase_s = 1'b0;
    end else if (cnt_r == period_r) begin
      cnt_s   = CNT_ZERO;
      phase_s = ~phase_r;
    end else begin
      cnt_s   = cnt_r + CNT_ONE;
      phase_s = phase_r;
    end

    if (wr_s) begin
      case (address)
        ADDR_DATA:   data_s  = wdata_s;
        ADDR_SET:    data_s  = data_q_r | wdata_s;
        ADDR_CLEAR:  data_s  = data_q_r & ~wdata_s;
        ADDR_BLINK:  blink_s = wdata_s;
        ADDR_PERIOD: begin
          // A new period restarts the timebase so a stale count never glitches.
          period_s = wperiod_s;
          cnt_s    = CNT_ZERO;
          phase_s  = 1'b0;
        end
        default: begin
          data_s = data_q_r;
        end
      endcase
    end else begin
      data_s = data_q_r;
    end
  end

  // State registers; out_port is registered from the next-state values so it
  // always equals data ^ (blink & phase) of the current register contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q_r <= RESET_VALUE;
      blink_r  <= DATA_ZERO;
      period_r <= CNT_ZERO;
      cnt_r    <= CNT_ZERO;
      phase_r  <= 1'b0;
      out_r    <= RESET_VALUE;
    end else begin
      data_q_r <= data_s;
      blink_r  <= blink_s;
      period_r <= period_s;
      cnt_r    <= cnt_s;
      phase_r  <= phase_s;
      out_r    <= data_s ^ (blink_s & {DATA_WIDTH{phase_s}});
    end
  end

  assign out_port = out_r ^ {DATA_WIDTH{data_r}};

  // Zero-wait read mux; reads have no side effects and ignore chipselect.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0] = data_q_r;
      ADDR_BLINK:  readdata[DATA_WIDTH-1:0] = blink_r;
      ADDR_PERIOD: readdata[CNT_WIDTH-1:0]  = period_r;
      ADDR_STATUS: readdata[0]              = phase_r;
      default:     readdata                 = 32'd0;
    endcase
  end

endmodule
